// File: rtl/store_to_fetch_receiver.sv
// store_to_fetch_receiver: buffers redirect packets from the store stage and
// presents them one at a time to fetch, pulsing fetch_flush after each one
// fetch accepts.
// Optional feature: define STORE_TO_FETCH_SKID_EN for a two-entry buffer so a
// second packet can be taken while the first is presented; undefined gives a
// single-entry buffer.
module store_to_fetch_receiver #(
  parameter int ADDR_W = 64,
  parameter int MASK_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s2f_can_receive,
  input  logic [ADDR_W+MASK_W-1:0] s2f_data,
  output logic                     s2f_recv,
  input  logic                     fetch_ready,
  output logic                     redirect_valid,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic [MASK_W-1:0]        redirect_mask,
  output logic                     fetch_flush,
  output logic [CNT_W-1:0]         redirect_count,
  output logic                     protocol_err
);

`ifdef STORE_TO_FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int DATA_W = ADDR_W + MASK_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_FLUSH} state_t;

  state_t            r_state;
  logic [OCC_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_valid;
  logic              r_flush;
  logic [ADDR_W-1:0] r_pc;
  logic [MASK_W-1:0] r_mask;
  logic [CNT_W-1:0]  r_redir_cnt;
  logic              r_err;
  logic              r_prev_can;
  logic              r_prev_recv;

  logic              w_push;
  logic              w_pop;
  logic [OCC_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_head;
  logic [PTR_W-1:0]  w_wr_ptr_inc;
  logic [PTR_W-1:0]  w_rd_ptr_inc;

  // Handshake, pop, next occupancy and the packet that would become the head.
  // When the buffer is empty the head is the packet being pushed right now,
  // which is what gives the one-cycle consume-to-present latency.
  always_comb begin
    w_push       = s2f_can_receive && (r_count < FULL_OCC) && !reset;
    w_pop        = (r_state == S_PRESENT) && fetch_ready;
    w_count_next = r_count + OCC_W'(w_push) - OCC_W'(w_pop);
    w_head       = (r_count == '0) ? s2f_data : r_mem[r_rd_ptr];
    w_wr_ptr_inc = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_inc = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
  end

  assign s2f_recv = w_push;

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s2f_data;
    end
  end

  // Occupancy and circular pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
    end
  end

  // Presentation FSM with registered valid/flush/head and the saturating
  // accepted-redirect counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_flush     <= 1'b0;
      r_pc        <= '0;
      r_mask      <= '0;
      r_redir_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_flush <= 1'b0;
          if (w_count_next != '0) begin
            r_state <= S_PRESENT;
            r_valid <= 1'b1;
            r_pc    <= w_head[ADDR_W-1:0];
            r_mask  <= w_head[DATA_W-1:ADDR_W];
          end
        end
        S_PRESENT: begin
          if (fetch_ready) begin
            r_state <= S_FLUSH;
            r_valid <= 1'b0;
            r_flush <= 1'b1;
            if (r_redir_cnt != '1) r_redir_cnt <= r_redir_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          r_flush <= 1'b0;
          if (w_count_next != '0) begin
            r_state <= S_PRESENT;
            r_valid <= 1'b1;
            r_pc    <= w_head[ADDR_W-1:0];
            r_mask  <= w_head[DATA_W-1:ADDR_W];
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error when the producer withdraws a packet that was never taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err       <= 1'b0;
      r_prev_can  <= 1'b0;
      r_prev_recv <= 1'b0;
    end else begin
      r_prev_can  <= s2f_can_receive;
      r_prev_recv <= w_push;
      if (r_prev_can && !s2f_can_receive && !r_prev_recv) r_err <= 1'b1;
    end
  end

  assign redirect_valid = r_valid;
  assign redirect_pc    = r_pc;
  assign redirect_mask  = r_mask;
  assign fetch_flush    = r_flush;
  assign redirect_count = r_redir_cnt;
  assign protocol_err   = r_err;

endmodule

// File: tb/tb_store_to_fetch_receiver.sv
// Directed bench for store_to_fetch_receiver. A second instance with a 2-bit
// redirect counter shares the stimulus so counter saturation is reached quickly.
module tb_store_to_fetch_receiver;

`ifdef STORE_TO_FETCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        s2f_can_receive;
  logic [95:0] s2f_data;
  logic        fetch_ready;

  logic        s2f_recv;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] redirect_mask;
  logic        fetch_flush;
  logic [15:0] redirect_count;
  logic        protocol_err;

  logic        sat_recv;
  logic        sat_valid;
  logic [63:0] sat_pc;
  logic [31:0] sat_mask;
  logic        sat_flush;
  logic [1:0]  sat_count;
  logic        sat_err;

  int n_checks = 0;
  int n_errors = 0;

  store_to_fetch_receiver dut (
    .clk(clk), .reset(reset),
    .s2f_can_receive(s2f_can_receive), .s2f_data(s2f_data), .s2f_recv(s2f_recv),
    .fetch_ready(fetch_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_mask(redirect_mask),
    .fetch_flush(fetch_flush), .redirect_count(redirect_count),
    .protocol_err(protocol_err)
  );

  store_to_fetch_receiver #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .s2f_can_receive(s2f_can_receive), .s2f_data(s2f_data), .s2f_recv(sat_recv),
    .fetch_ready(fetch_ready), .redirect_valid(sat_valid),
    .redirect_pc(sat_pc), .redirect_mask(sat_mask),
    .fetch_flush(sat_flush), .redirect_count(sat_count),
    .protocol_err(sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pkt(input logic [63:0] pc, input logic [31:0] mask);
    return {mask, pc};
  endfunction

  // Offer a packet and hold it until consumed, then withdraw it.
  task automatic send(input logic [63:0] pc, input logic [31:0] mask);
    logic taken;
    taken = 1'b0;
    s2f_can_receive = 1'b1;
    s2f_data = pkt(pc, mask);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (s2f_recv) begin
        taken = 1'b1;
        break;
      end
      step();
    end
    check_val("send_taken", {63'd0, taken}, 64'd1);
    step();
    s2f_can_receive = 1'b0;
  endtask

  // Send one packet and let fetch accept it immediately.
  task automatic deliver(input logic [63:0] pc, input logic [31:0] mask);
    send(pc, mask);
    check_val("dl_valid", {63'd0, redirect_valid}, 64'd1);
    check_val("dl_pc", redirect_pc, pc);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    check_val("dl_flush", {63'd0, fetch_flush}, 64'd1);
    step();
  endtask

  initial begin
    reset = 1'b1;
    s2f_can_receive = 1'b0;
    s2f_data = '0;
    fetch_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check_val("rst_valid", {63'd0, redirect_valid}, 64'd0);
    check_val("rst_flush", {63'd0, fetch_flush}, 64'd0);
    check_val("rst_count", {48'd0, redirect_count}, 64'd0);
    check_val("rst_err", {63'd0, protocol_err}, 64'd0);
    check_val("rst_pc", redirect_pc, 64'd0);
    check_val("rst_mask", {32'd0, redirect_mask}, 64'd0);

    // Single packet, fetch_ready held high
    s2f_can_receive = 1'b1;
    s2f_data = pkt(64'h1000, 32'hFFFF_FFFF);
    fetch_ready = 1'b1;
    #1;
    check_val("rst_recv_blocked", {63'd0, s2f_recv}, 64'd0);
    reset = 1'b0;
    #1;
    check_val("t1_recv_c0", {63'd0, s2f_recv}, 64'd1);
    step();
    check_val("t1_valid_c1", {63'd0, redirect_valid}, 64'd1);
    check_val("t1_pc_c1", redirect_pc, 64'h1000);
    check_val("t1_mask_c1", {32'd0, redirect_mask}, 64'hFFFF_FFFF);
    check_val("t1_flush_c1", {63'd0, fetch_flush}, 64'd0);
    s2f_can_receive = 1'b0;
    #1;
    check_val("t1_recv_c1", {63'd0, s2f_recv}, 64'd0);
    step();
    check_val("t1_flush_c2", {63'd0, fetch_flush}, 64'd1);
    check_val("t1_valid_c2", {63'd0, redirect_valid}, 64'd0);
    check_val("t1_count", {48'd0, redirect_count}, 64'd1);
    step();
    check_val("t1_flush_c3", {63'd0, fetch_flush}, 64'd0);
    check_val("t1_valid_c3", {63'd0, redirect_valid}, 64'd0);
    fetch_ready = 1'b0;

    // Back-to-back packets with fetch stalled
    s2f_can_receive = 1'b1;
    s2f_data = pkt(64'h2000, 32'hA);
    #1;
    check_val("t2_recv_a", {63'd0, s2f_recv}, 64'd1);
    step();
    s2f_data = pkt(64'h3000, 32'hB);
    #1;
    check_val("t2_recv_b", {63'd0, s2f_recv}, {63'd0, SKID});
    check_val("t2_valid_a", {63'd0, redirect_valid}, 64'd1);
    check_val("t2_pc_a", redirect_pc, 64'h2000);
    step();
`ifdef STORE_TO_FETCH_SKID_EN
    s2f_can_receive = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t2_hold_valid", {63'd0, redirect_valid}, 64'd1);
      check_val("t2_hold_pc", redirect_pc, 64'h2000);
      check_val("t2_hold_recv", {63'd0, s2f_recv}, 64'd0);
    end
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    #1;
    check_val("t2_flush_a", {63'd0, fetch_flush}, 64'd1);
    check_val("t2_valid_fl", {63'd0, redirect_valid}, 64'd0);
    check_val("t2_recv_fl", {63'd0, s2f_recv}, {63'd0, !SKID});
    step();
    s2f_can_receive = 1'b0;
    check_val("t2_valid_b", {63'd0, redirect_valid}, 64'd1);
    check_val("t2_pc_b", redirect_pc, 64'h3000);
    check_val("t2_mask_b", {32'd0, redirect_mask}, 64'hB);
    check_val("t2_count_a", {48'd0, redirect_count}, 64'd2);
    fetch_ready = 1'b1;
    step();
    check_val("t2_flush_b", {63'd0, fetch_flush}, 64'd1);
    check_val("t2_count_b", {48'd0, redirect_count}, 64'd3);
    step();
    check_val("t2_idle_flush", {63'd0, fetch_flush}, 64'd0);
    check_val("t2_idle_valid", {63'd0, redirect_valid}, 64'd0);

    // fetch_ready toggling outside PRESENT has no effect
    for (int i = 0; i < 4; i++) begin
      fetch_ready = i[0];
      step();
      check_val("t3_tog_flush", {63'd0, fetch_flush}, 64'd0);
      check_val("t3_tog_valid", {63'd0, redirect_valid}, 64'd0);
      check_val("t3_tog_count", {48'd0, redirect_count}, 64'd3);
    end
    fetch_ready = 1'b0;
    check_val("sat_count_3", {62'd0, sat_count}, 64'd3);

    // Reset while presenting with the buffer full and a packet pending
    send(64'h4000, 32'h4);
`ifdef STORE_TO_FETCH_SKID_EN
    send(64'h4100, 32'h41);
`endif
    s2f_can_receive = 1'b1;
    s2f_data = pkt(64'h5000, 32'h5);
    #1;
    check_val("t4_recv_full", {63'd0, s2f_recv}, 64'd0);
    step();
    check_val("t4_valid_pre", {63'd0, redirect_valid}, 64'd1);
    check_val("t4_pc_pre", redirect_pc, 64'h4000);
    reset = 1'b1;
    #1;
    check_val("t4_recv_in_rst", {63'd0, s2f_recv}, 64'd0);
    step();
    check_val("t4_valid_rst", {63'd0, redirect_valid}, 64'd0);
    check_val("t4_flush_rst", {63'd0, fetch_flush}, 64'd0);
    check_val("t4_count_rst", {48'd0, redirect_count}, 64'd0);
    reset = 1'b0;
    #1;
    check_val("t4_recv_post", {63'd0, s2f_recv}, 64'd1);
    step();
    s2f_can_receive = 1'b0;
    check_val("t4_valid_c", {63'd0, redirect_valid}, 64'd1);
    check_val("t4_pc_c", redirect_pc, 64'h5000);
    check_val("t4_mask_c", {32'd0, redirect_mask}, 64'h5);
    check_val("t4_err_post", {63'd0, protocol_err}, 64'd0);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    check_val("t4_flush_c", {63'd0, fetch_flush}, 64'd1);
    check_val("t4_count_c", {48'd0, redirect_count}, 64'd1);
    step();
    check_val("t4_idle_valid", {63'd0, redirect_valid}, 64'd0);

    // Counter saturation on the narrow-counter instance
    for (int i = 0; i < 4; i++) begin
      deliver(64'h6000 + 64'(i * 256), 32'(i));
      check_val("t5_count", {48'd0, redirect_count}, 64'(2 + i));
      check_val("t5_sat", {62'd0, sat_count}, (2 + i > 3) ? 64'd3 : 64'(2 + i));
    end
    check_val("t5_err", {63'd0, protocol_err}, 64'd0);

    // Withdrawn packet raises a sticky error
    send(64'h7000, 32'h7);
`ifdef STORE_TO_FETCH_SKID_EN
    send(64'h7100, 32'h71);
`endif
    s2f_can_receive = 1'b1;
    s2f_data = pkt(64'h7200, 32'h72);
    #1;
    check_val("t6_recv_full", {63'd0, s2f_recv}, 64'd0);
    step();
    s2f_can_receive = 1'b0;
    check_val("t6_err_before", {63'd0, protocol_err}, 64'd0);
    step();
    check_val("t6_err_set", {63'd0, protocol_err}, 64'd1);
    repeat (3) step();
    check_val("t6_err_held", {63'd0, protocol_err}, 64'd1);
    reset = 1'b1;
    step();
    check_val("t6_err_rst", {63'd0, protocol_err}, 64'd0);
    reset = 1'b0;
    step();
    check_val("t6_err_after", {63'd0, protocol_err}, 64'd0);
    check_val("t6_valid_after", {63'd0, redirect_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_to_fetch_receiver.md
STORE_TO_FETCH_RECEIVER -- requirements
Module: store_to_fetch_receiver

Interface
REQ-001 Parameters (name, default, meaning), SHALL exist:
- ADDR_W, 64, redirect PC width.
- MASK_W, 32, execution-mask width.
- CNT_W, 16, redirect counter width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s2f_can_receive  input  1  store stage has a packet pending; held high until consumed.
REQ-005 s2f_data  input  ADDR_W+MASK_W  packet {exec_mask[MASK_W-1:0], next_pc[ADDR_W-1:0]}; stable while s2f_can_receive=1.
REQ-006 s2f_recv  output  1  consume strobe; combinational; the packet is taken on the edge where it is high.
REQ-007 fetch_ready  input  1  fetch accepts the presented redirect this cycle.
REQ-008 redirect_valid  output  1  redirect presented to fetch.
REQ-009 redirect_pc  output  ADDR_W  buffered head next_pc.
REQ-010 redirect_mask  output  MASK_W  buffered head exec_mask.
REQ-011 fetch_flush  output  1  one-cycle pulse after each accepted redirect.
REQ-012 redirect_count  output  CNT_W  accepted redirects, saturating.
REQ-013 protocol_err  output  1  sticky protocol violation flag.

Function
REQ-014 The block SHALL hold packets in a FIFO of DEPTH entries (DEPTH per REQ-030) with a registered occupancy count.
REQ-015 s2f_recv SHALL equal s2f_can_receive && (count < DEPTH) && !reset; the push SHALL be blocked when full, even if a pop occurs in the same cycle.
REQ-016 On an edge with s2f_recv=1, s2f_data SHALL be written at the tail.
REQ-017 FSM states SHALL be IDLE, PRESENT and FLUSH.
REQ-018 Transitions:
- IDLE->PRESENT when count>0.
- PRESENT->FLUSH on fetch_ready=1, which pops the head.
- FLUSH->PRESENT when count>0 after the pop; otherwise FLUSH->IDLE.
REQ-019 redirect_valid SHALL be 1 only in PRESENT; redirect_pc and redirect_mask SHALL show the FIFO head and SHALL be stable while valid.
REQ-020 fetch_ready SHALL be ignored outside PRESENT.
REQ-021 Latency: a packet consumed at edge N into an empty FIFO SHALL raise redirect_valid in cycle N+1.
REQ-022 fetch_flush SHALL be 1 exactly in FLUSH cycles, one cycle per accepted redirect.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; pointers SHALL wrap modulo DEPTH.
REQ-024 redirect_count SHALL increment on each PRESENT->FLUSH transition and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 protocol_err SHALL be set when s2f_can_receive goes 1->0 without s2f_recv=1 on the preceding edge; it SHALL be cleared only by reset.

Reset
REQ-026 While reset=1: FSM=IDLE, count=0, pointers=0, redirect_count=0, protocol_err=0, redirect_valid=0, fetch_flush=0, s2f_recv=0.
REQ-027 redirect_pc and redirect_mask SHALL reset to 0; FIFO storage SHALL NOT require a reset.
REQ-028 Reset asserted mid-PRESENT or mid-FLUSH SHALL discard all buffered packets; a packet pending on the bus is not consumed during reset and SHALL be taken on the first cycle after reset.
REQ-029 protocol_err edge detection SHALL restart after reset, so no error is raised for the cycle in which reset deasserts.

Configuration
REQ-030 Macro STORE_TO_FETCH_SKID_EN: defined -> DEPTH=2, so a second packet is accepted while the first is presented; undefined -> DEPTH=1, so s2f_recv stays low from the consume edge until the FLUSH cycle. All other behaviour is identical.

Verification
REQ-031 Single packet, pc=0x1000, mask=0xFFFF_FFFF, fetch_ready held 1 -> s2f_recv in cycle 0, redirect_valid in cycle 1, fetch_flush in cycle 2, redirect_count=1.
REQ-032 Back-to-back packets 0x2000 then 0x3000, fetch_ready=0 for 5 cycles -> with SKID_EN both consumed and count=2; without it the second waits on the bus; delivery order 0x2000 then 0x3000.
REQ-033 fetch_ready toggling 0,1 while in FLUSH/IDLE -> no extra pop, no extra flush pulse, redirect_count unchanged.
REQ-034 Reset asserted in PRESENT with 2 entries buffered -> next cycle redirect_valid=0, count=0, FIFO empty; pending bus packet taken after reset drops.
REQ-035 Force redirect_count to 0xFFFE, accept 3 redirects -> count ends at 0xFFFF.
REQ-036 Drop s2f_can_receive with no prior s2f_recv -> protocol_err=1 next cycle and held until reset.
